qsfp_mgmt_ctrl: RTL and testbench

QSFP_MGMT_CTRL -- requirements
Module: qsfp_mgmt_ctrl

---
 rtl/qsfp_mgmt_ctrl.sv | 163 ++++++++++++++++
 tb/tb_qsfp_mgmt_ctrl.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/qsfp_mgmt_ctrl.sv
// QSFP cage management: per-port presence debounce, ResetL/init sequencing,
// host control of ModSelL/LPMode and a sticky interrupt latch.
`timescale 1ns/1ps
module qsfp_mgmt_ctrl #(
    parameter int NUM_PORTS         = 2,
    parameter int DEBOUNCE_CYCLES   = 1024,
    parameter int RESET_HOLD_CYCLES = 256,
    parameter int INIT_WAIT_CYCLES  = 4096
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_PORTS-1:0] qsfp_modprsl_ls,
    input  logic [NUM_PORTS-1:0] qsfp_intl_ls,
    output logic [NUM_PORTS-1:0] qsfp_modsell_ls,
    output logic [NUM_PORTS-1:0] qsfp_resetl_ls,
    output logic [NUM_PORTS-1:0] qsfp_lpmode_ls,
    input  logic [NUM_PORTS-1:0] modsel_req,
    input  logic [NUM_PORTS-1:0] lpmode_req,
    input  logic [NUM_PORTS-1:0] reset_req,
    input  logic [NUM_PORTS-1:0] int_clear,
    output logic [NUM_PORTS-1:0] port_ready,
    output logic [NUM_PORTS-1:0] int_pending,
    output logic [NUM_PORTS-1:0] led_present,
    output logic [NUM_PORTS-1:0] led_int
);

    localparam int MAX_AB  = (DEBOUNCE_CYCLES > RESET_HOLD_CYCLES) ? DEBOUNCE_CYCLES : RESET_HOLD_CYCLES;
    localparam int MAX_CYC = (MAX_AB > INIT_WAIT_CYCLES) ? MAX_AB : INIT_WAIT_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RH_LAST = CNT_W'(RESET_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] IW_LAST = CNT_W'(INIT_WAIT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_ABSENT,
        ST_DEBOUNCE,
        ST_RESET_ASSERT,
        ST_INIT_WAIT,
        ST_READY
    } state_t;

    state_t           state_q [NUM_PORTS];
    state_t           state_d [NUM_PORTS];
    logic [CNT_W-1:0] cnt_q   [NUM_PORTS];
    logic [CNT_W-1:0] cnt_d   [NUM_PORTS];

    // Synchronisers hold the inverted pins so a cleared flop means "inactive".
    logic [NUM_PORTS-1:0] prs_meta_q, prs_sync_q, int_meta_q, int_sync_q;

    logic [NUM_PORTS-1:0] modsell_q, modsell_d, resetl_q, resetl_d, lpmode_q, lpmode_d;
    logic [NUM_PORTS-1:0] ready_q, ready_d, int_pend_q, int_pend_d, led_prs_q, led_prs_d;

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];

            // Removal is undebounced and overrides every other transition.
            if (!prs_sync_q[i]) begin
                state_d[i] = ST_ABSENT;
                cnt_d[i]   = '0;
            end else begin
                unique case (state_q[i])
                    ST_ABSENT: begin
                        state_d[i] = ST_DEBOUNCE;
                        cnt_d[i]   = '0;
                    end
                    ST_DEBOUNCE: begin
                        if (cnt_q[i] == DB_LAST) begin
                            state_d[i] = ST_RESET_ASSERT;
                            cnt_d[i]   = '0;
                        end else begin
                            cnt_d[i] = cnt_q[i] + 1'b1;
                        end
                    end
                    ST_RESET_ASSERT: begin
                        if (cnt_q[i] == RH_LAST) begin
                            state_d[i] = ST_INIT_WAIT;
                            cnt_d[i]   = '0;
                        end else begin
                            cnt_d[i] = cnt_q[i] + 1'b1;
                        end
                    end
                    ST_INIT_WAIT: begin
                        if (reset_req[i]) begin
                            state_d[i] = ST_RESET_ASSERT;
                            cnt_d[i]   = '0;
                        end else if (cnt_q[i] == IW_LAST) begin
                            state_d[i] = ST_READY;
                            cnt_d[i]   = '0;
                        end else begin
                            cnt_d[i] = cnt_q[i] + 1'b1;
                        end
                    end
                    ST_READY: begin
                        if (reset_req[i]) begin
                            state_d[i] = ST_RESET_ASSERT;
                            cnt_d[i]   = '0;
                        end
                    end
                    default: begin
                        state_d[i] = ST_ABSENT;
                        cnt_d[i]   = '0;
                    end
                endcase
            end

            resetl_d[i]   = (state_q[i] == ST_INIT_WAIT) || (state_q[i] == ST_READY);
            lpmode_d[i]   = (state_q[i] == ST_READY) ? lpmode_req[i] : 1'b1;
            modsell_d[i]  = !((state_q[i] == ST_READY) && modsel_req[i]);
            ready_d[i]    = (state_q[i] == ST_READY);
            led_prs_d[i]  = (state_q[i] == ST_RESET_ASSERT) || (state_q[i] == ST_INIT_WAIT) ||
                            (state_q[i] == ST_READY);
            // New interrupt beats a same-cycle clear; the latch drops outside READY.
            int_pend_d[i] = (state_q[i] == ST_READY) ?
                            (int_sync_q[i] | (int_pend_q[i] & ~int_clear[i])) : 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                state_q[i] <= ST_ABSENT;
                cnt_q[i]   <= '0;
            end
            prs_meta_q <= '0;
            prs_sync_q <= '0;
            int_meta_q <= '0;
            int_sync_q <= '0;
            modsell_q  <= '1;
            resetl_q   <= '0;
            lpmode_q   <= '1;
            ready_q    <= '0;
            int_pend_q <= '0;
            led_prs_q  <= '0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            prs_meta_q <= ~qsfp_modprsl_ls;
            prs_sync_q <= prs_meta_q;
            int_meta_q <= ~qsfp_intl_ls;
            int_sync_q <= int_meta_q;
            modsell_q  <= modsell_d;
            resetl_q   <= resetl_d;
            lpmode_q   <= lpmode_d;
            ready_q    <= ready_d;
            int_pend_q <= int_pend_d;
            led_prs_q  <= led_prs_d;
        end
    end

    assign qsfp_modsell_ls = modsell_q;
    assign qsfp_resetl_ls  = resetl_q;
    assign qsfp_lpmode_ls  = lpmode_q;
    assign port_ready      = ready_q;
    assign int_pending     = int_pend_q;
    assign led_present     = led_prs_q;
    assign led_int         = int_pend_q;

endmodule

// File: tb/tb_qsfp_mgmt_ctrl.sv
// Randomized bench for qsfp_mgmt_ctrl: a run-length/elapsed-time reference model
// predicts every registered output every cycle.
`timescale 1ns/1ps
module tb_qsfp_mgmt_ctrl;

    localparam int NP = 2;
    localparam int DB = 4;
    localparam int RH = 3;
    localparam int IW = 5;
    localparam int NCYC = 3000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NP-1:0] modprsl = '1, intl = '1;
    logic [NP-1:0] modsell, resetl, lpmode;
    logic [NP-1:0] modsel_req = '0, lpmode_req = '0, reset_req = '0, int_clear = '0;
    logic [NP-1:0] ready, int_pend, led_prs, led_irq;

    always #5 clk = ~clk;

    qsfp_mgmt_ctrl #(
        .NUM_PORTS(NP), .DEBOUNCE_CYCLES(DB), .RESET_HOLD_CYCLES(RH), .INIT_WAIT_CYCLES(IW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .qsfp_modprsl_ls(modprsl), .qsfp_intl_ls(intl),
        .qsfp_modsell_ls(modsell), .qsfp_resetl_ls(resetl), .qsfp_lpmode_ls(lpmode),
        .modsel_req(modsel_req), .lpmode_req(lpmode_req),
        .reset_req(reset_req), .int_clear(int_clear),
        .port_ready(ready), .int_pending(int_pend),
        .led_present(led_prs), .led_int(led_irq)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: pin history through two delay slots, length of the
    // current present run, and cycles elapsed since the last ResetL assertion.
    bit s1 [NP], s2 [NP], is1 [NP], is2 [NP];
    int run [NP], age [NP];
    bit acc [NP], ip [NP];
    int hold [NP];
    bit lvl [NP];
    logic [NP-1:0] e_msl, e_rst, e_lp, e_rdy, e_ip, e_led;

    // 0 = not yet accepted, 1 = ResetL held, 2 = init wait, 3 = ready
    function automatic int phase(input int p);
        if (!acc[p])             return 0;
        else if (age[p] < RH)    return 1;
        else if (age[p] < RH+IW) return 2;
        else                     return 3;
    endfunction

    task automatic model_reset();
        for (int p = 0; p < NP; p++) begin
            s1[p] = 0; s2[p] = 0; is1[p] = 0; is2[p] = 0;
            run[p] = 0; age[p] = 0; acc[p] = 0; ip[p] = 0;
        end
        e_msl = '1; e_rst = '0; e_lp = '1; e_rdy = '0; e_ip = '0; e_led = '0;
    endtask

    task automatic model_step();
        for (int p = 0; p < NP; p++) begin
            int ph;
            ph = phase(p);
            e_rst[p] = (ph >= 2);
            e_lp[p]  = (ph == 3) ? lpmode_req[p] : 1'b1;
            e_msl[p] = !(ph == 3 && modsel_req[p]);
            e_rdy[p] = (ph == 3);
            e_led[p] = (ph >= 1);
            ip[p]    = (ph == 3) ? (is2[p] | (ip[p] & !int_clear[p])) : 1'b0;
            e_ip[p]  = ip[p];
            if (!s2[p]) begin
                run[p] = 0;
                acc[p] = 0;
            end else begin
                run[p]++;
                if (!acc[p]) begin
                    if (run[p] == DB + 1) begin
                        acc[p] = 1;
                        age[p] = 0;
                    end
                end else if (reset_req[p] && ph >= 2) begin
                    age[p] = 0;
                end else if (age[p] < 100000) begin
                    age[p]++;
                end
            end
            s2[p]  = s1[p];  s1[p]  = !modprsl[p];
            is2[p] = is1[p]; is1[p] = !intl[p];
        end
    endtask

    task automatic check_outputs(input string pfx);
        chk({pfx, "_modsell"}, 32'(modsell),  32'(e_msl));
        chk({pfx, "_resetl"},  32'(resetl),   32'(e_rst));
        chk({pfx, "_lpmode"},  32'(lpmode),   32'(e_lp));
        chk({pfx, "_ready"},   32'(ready),    32'(e_rdy));
        chk({pfx, "_intpend"}, 32'(int_pend), 32'(e_ip));
        chk({pfx, "_ledprs"},  32'(led_prs),  32'(e_led));
        chk({pfx, "_ledint"},  32'(led_irq),  32'(e_ip));
    endtask

    initial begin
        model_reset();
        for (int p = 0; p < NP; p++) begin
            hold[p] = 0;
            lvl[p]  = 0;
        end
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            for (int p = 0; p < NP; p++) begin
                if (hold[p] == 0) begin
                    lvl[p]  = ($urandom_range(0, 2) != 0);
                    hold[p] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : $urandom_range(10, 45);
                end
                hold[p]--;
                modprsl[p]    = !lvl[p];
                intl[p]       = ($urandom_range(0, 7) != 0);
                reset_req[p]  = ($urandom_range(0, 39) == 0);
                int_clear[p]  = ($urandom_range(0, 5) == 0);
                modsel_req[p] = $urandom_range(0, 1);
                lpmode_req[p] = $urandom_range(0, 1);
            end
            rst_n = !((cyc < 3) || (cyc >= 900 && cyc < 903) || (cyc >= 1900 && cyc < 1904));
            if (!rst_n) begin
                // Asynchronous reset must take effect before the next clock edge.
                #1;
                model_reset();
                check_outputs("async_rst");
            end
            @(posedge clk);
            if (!rst_n) model_reset();
            else        model_step();
            #1;
            check_outputs("cyc");
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
